// File: rtl/sig_monitor_if.sv
// rtl/sig_monitor_if.sv - snooped data-write bus and signature stream between core side and sig_monitor
//
// Signals:
//   dmem_wr_addr[31:0], dmem_wr_data[31:0], dmem_wr_en : core data-memory write port (snooped)
//   sig_valid, sig_ready, sig_data[31:0], sig_index[9:0] : signature word stream with valid/ready handshake
// Modports:
//   master : core/bench side, drives writes and accepts the stream
//   slave  : sig_monitor side, observes writes and presents the stream
interface sig_monitor_if;
    logic [31:0] dmem_wr_addr;
    logic [31:0] dmem_wr_data;
    logic        dmem_wr_en;
    logic        sig_valid;
    logic        sig_ready;
    logic [31:0] sig_data;
    logic [9:0]  sig_index;

    modport master (
        output dmem_wr_addr, dmem_wr_data, dmem_wr_en, sig_ready,
        input  sig_valid, sig_data, sig_index
    );

    modport slave (
        input  dmem_wr_addr, dmem_wr_data, dmem_wr_en, sig_ready,
        output sig_valid, sig_data, sig_index
    );
endinterface

// File: rtl/sig_monitor.sv
// rtl/sig_monitor.sv - end-of-test monitor: signature capture, tohost halt detect, signature stream-out
//
// Ports:
//   sysclk  in  : clock, all state on rising edge
//   nrst_in in  : asynchronous active-low reset
//   bus         : sig_monitor_if.slave (snooped dmem writes in, signature stream out)
//   done    out : dump complete, sticky
//   pass    out : halt value was exactly 1, sticky
//   timeout out : watchdog fired, sticky (tied 0 unless SIG_MONITOR_TIMEOUT_EN is defined)
// Optional feature macro: SIG_MONITOR_TIMEOUT_EN (watchdog counter in RUN)
module sig_monitor #(
    parameter logic [31:0] SIG_BASE       = 32'h0000_2000,
    parameter int          SIG_WORDS      = 64,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic          sysclk,
    input  logic          nrst_in,
    sig_monitor_if.slave  bus,
    output logic          done,
    output logic          pass,
    output logic          timeout
);
    localparam int IW = (SIG_WORDS > 1) ? $clog2(SIG_WORDS) : 1;
    // 33-bit end address so a region touching the top of memory does not wrap
    localparam logic [32:0] SIG_END = {1'b0, SIG_BASE} + 33'(4 * SIG_WORDS);
    localparam logic [IW-1:0] LAST_WORD = IW'(SIG_WORDS - 1);

    if (SIG_WORDS < 1 || SIG_WORDS > 1024) begin : g_bad_words
        $error("sig_monitor: SIG_WORDS out of range");
    end
    if (SIG_BASE[1:0] != 2'b00) begin : g_bad_base
        $error("sig_monitor: SIG_BASE not word aligned");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("sig_monitor: TIMEOUT_CYCLES must be positive");
    end

    typedef enum logic [1:0] {RUN, DUMP, DONE} state_t;

    state_t            state;
    logic [31:0]       sig_mem [SIG_WORDS];
    logic [SIG_WORDS-1:0] written;
    logic [IW-1:0]     rd_ptr;
    logic [31:0]       sig_data_q;
    logic              sig_valid_q;

    logic              in_region;
    logic              capture;
    logic              halt;
    logic [IW-1:0]     wr_word;
    logic [IW-1:0]     next_ptr;
    logic [31:0]       next_word;

    assign in_region = ({1'b0, bus.dmem_wr_addr} >= {1'b0, SIG_BASE}) &&
                       ({1'b0, bus.dmem_wr_addr} <  SIG_END);
    assign wr_word   = IW'((bus.dmem_wr_addr - SIG_BASE) >> 2);
    assign capture   = (state == RUN) && bus.dmem_wr_en &&
                       (bus.dmem_wr_addr[1:0] == 2'b00) && in_region;
    assign halt      = (state == RUN) && bus.dmem_wr_en &&
                       (bus.dmem_wr_addr == TOHOST_ADDR) && bus.dmem_wr_data[0];

    // Word to present after the coming edge. On the halt edge that is word 0,
    // and a capture on that same edge is forwarded since storage lands only at the edge.
    always_comb begin
        next_ptr = (state == RUN) ? '0 : rd_ptr + 1'b1;
        if (capture && (wr_word == next_ptr))
            next_word = bus.dmem_wr_data;
        else if (written[next_ptr])
            next_word = sig_mem[next_ptr];
        else
            next_word = 32'h0;
    end

    // Signature storage is deliberately not reset; the written flags mask stale data.
    always_ff @(posedge sysclk) begin
        if (capture)
            sig_mem[wr_word] <= bus.dmem_wr_data;
    end

`ifdef SIG_MONITOR_TIMEOUT_EN
    logic [31:0] cycle_cnt;
    logic        timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge sysclk or negedge nrst_in) begin
        if (!nrst_in) begin
            state       <= RUN;
            written     <= '0;
            rd_ptr      <= '0;
            sig_data_q  <= 32'h0;
            sig_valid_q <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
`ifdef SIG_MONITOR_TIMEOUT_EN
            cycle_cnt   <= 32'h0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (capture)
                        written[wr_word] <= 1'b1;
                    if (halt) begin
                        pass        <= (bus.dmem_wr_data == 32'h1);
                        state       <= DUMP;
                        rd_ptr      <= '0;
                        sig_data_q  <= next_word;
                        sig_valid_q <= 1'b1;
                    end
`ifdef SIG_MONITOR_TIMEOUT_EN
                    // Halt has priority over a watchdog expiring on the same edge.
                    else if (cycle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q   <= 1'b1;
                        pass        <= 1'b0;
                        state       <= DUMP;
                        rd_ptr      <= '0;
                        sig_data_q  <= next_word;
                        sig_valid_q <= 1'b1;
                    end
                    cycle_cnt <= cycle_cnt + 32'h1;
`endif
                end
                DUMP: begin
                    if (sig_valid_q && bus.sig_ready) begin
                        if (rd_ptr == LAST_WORD) begin
                            sig_valid_q <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            rd_ptr     <= next_ptr;
                            sig_data_q <= next_word;
                        end
                    end
                end
                DONE: begin
                    sig_valid_q <= 1'b0;
                    done        <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.sig_valid = sig_valid_q;
    assign bus.sig_data  = sig_data_q;
    assign bus.sig_index = 10'(rd_ptr);
endmodule

// File: doc/sig_monitor.md
# sig_monitor

Synthesizable end-of-test monitor for the RV32I core. It sits directly downstream of the core's external data-memory write port, beside the testbench memory model. It snoops data writes, keeps a shadow copy of the compliance signature region and detects the halt write to the `tohost` address. It then streams the captured signature out over a valid/ready port so the bench can write the signature file.

## Interface
Parameters:
- `SIG_BASE`, default 32'h0000_2000: byte address of signature word 0; must be 4-byte aligned.
- `SIG_WORDS`, default 64: number of 32-bit signature words captured; range 1–1024.
- `TOHOST_ADDR`, default 32'h0000_1000: byte address of the halt/status word.
- `TIMEOUT_CYCLES`, default 100000: watchdog limit in cycles. Used only when the timeout feature is compiled in.

Ports:
- `sysclk` in 1: single clock; all state updates on its rising edge.
- `nrst_in` in 1: reset. Asynchronous and active-low.
- `dmem_wr_addr` in 32: core data write byte address.
- `dmem_wr_data` in 32: core data write value.
- `dmem_wr_en` in 1: write strobe, one write per cycle.
- `sig_valid` out 1: signature word available.
- `sig_ready` in 1: consumer accepts the word.
- `sig_data` out 32: signature word.
- `sig_index` out 10: word index of `sig_data`, starting at 0.
- `done` out 1: dump complete, sticky.
- `pass` out 1: halt value equalled 1, sticky.
- `timeout` out 1: watchdog fired, sticky.

## Operation
- The FSM has three states: RUN, DUMP and DONE. Reset enters RUN.
- **Reset values:** `sig_valid`=0, `sig_data`=0, `sig_index`=0, `done`=0, `pass`=0, `timeout`=0. All per-word written flags are cleared. Signature storage is not reset.
- **RUN, signature capture:**
  - Trigger: `dmem_wr_en`=1, `dmem_wr_addr[1:0]`=0, and the address lies in [SIG_BASE, SIG_BASE+4*SIG_WORDS).
  - Action: store `dmem_wr_data` at word `(addr-SIG_BASE)>>2` and set that word's written flag.
  - A later write to the same word overwrites it.
- **Ignored in RUN:** unaligned writes and addresses outside the region, including SIG_BASE+4*SIG_WORDS exactly.
- **RUN, halt detection:**
  - Trigger: `dmem_wr_en`=1, `dmem_wr_addr`==TOHOST_ADDR and `dmem_wr_data[0]`=1.
  - Action: latch `pass` = (`dmem_wr_data`==32'h1), then go to DUMP.
  - A `tohost` write with bit0=0 is ignored.
  - If TOHOST_ADDR lies inside the signature region, that same write is also captured.
- **DUMP:**
  - Present word `sig_index`. `sig_data` is the stored value if its written flag is set, else 32'h0.
  - On `sig_valid && sig_ready`: advance `sig_index`. If the accepted word is the last one (SIG_WORDS-1), deassert `sig_valid` and go to DONE.
  - `sig_data` and `sig_index` are registered and hold stable while `sig_valid && !sig_ready`.
- **Ignored in DUMP and DONE:** all data writes; the snapshot is frozen.
- **DONE:** `done`=1, `sig_valid`=0. The block stays in DONE until reset.
- **Reset mid-operation:** an asynchronous reset in any state returns the block to RUN with all outputs at their reset values. A partially dumped signature is discarded.

## Timing
- Capture: a write sampled at edge N is visible in the dump with no further constraint; storage is written at N.
- Halt write sampled at edge N:
  - State is DUMP after N.
  - `sig_valid`=1 with `sig_index`=0 and word 0 on `sig_data` in cycle N+1.
- With `sig_ready` held at 1, one word transfers per cycle, so the dump takes SIG_WORDS cycles.
- `done` rises in the cycle after the last handshake edge.
- `sig_ready` may toggle freely. A word transfers only on an edge where `sig_valid && sig_ready`.

## Configuration
- Macro: `SIG_MONITOR_TIMEOUT_EN`.
- **Defined:**
  - A cycle counter runs in RUN, starting at 0 on reset.
  - When it reaches TIMEOUT_CYCLES with no halt, the block sets `timeout`=1, forces `pass`=0 and enters DUMP on the next cycle, exactly as for a halt.
  - A halt and the timeout on the same edge: the halt wins and `timeout` stays 0.
- **Undefined:** no counter is built, `timeout` is tied to 0, and RUN lasts until a halt write.

## Test plan
- **Basic dump:** SIG_WORDS=4; write 0x11 @SIG_BASE, 0x22 @SIG_BASE+8; write 1 @TOHOST_ADDR; `sig_ready`=1. Expect the stream 0x11, 0x0, 0x22, 0x0 at indices 0–3 on consecutive cycles starting the cycle after the halt, then `done`=1 and `pass`=1.
- **Backpressure:** same as the basic dump, but `sig_ready` is low for 3 cycles at index 1. Expect `sig_data`=0x0 and `sig_index`=1 held stable for those cycles, then the dump resumes with no word lost or duplicated.
- **Filtering and failing halt:**
  - Writes to SIG_BASE-4 and SIG_BASE+16 (SIG_WORDS=4), a write to SIG_BASE+2, and a `tohost` write of 0x0: all ignored.
  - Then a `tohost` write of 0x7: DUMP entered, `pass`=0.
- **Overwrite and post-halt freeze:** write 0xA then 0xB @SIG_BASE, halt, then write 0xC @SIG_BASE during DUMP. Expect word 0 = 0xB.
- **Reset mid-dump:** assert `nrst_in`=0 asynchronously at index 2. Expect all outputs 0 immediately and state RUN after release. A new halt gives a dump of all zeros.
- **Timeout (`SIG_MONITOR_TIMEOUT_EN`, TIMEOUT_CYCLES=20):** no halt. Expect `timeout`=1, `pass`=0, and DUMP starting within 22 cycles of reset release. Without the macro, no dump occurs after 1000 cycles.
